// File: rtl/rounding_divider_pipe_if.sv
// rounding_divider_pipe_if
// Valid/ready stream bundle for rounding_divider_pipe.
//   in_valid/in_ready : input handshake; din, shift, mode ride with it
//   out_valid/out_ready : output handshake; dout, sat ride with it
// Modports: master = stream producer/consumer side (testbench or upstream),
//           slave  = the divider itself.
interface rounding_divider_pipe_if #(
  parameter int IN_WIDTH  = 35,
  parameter int OUT_WIDTH = 32,
  parameter int MAX_SHIFT = 7,
  localparam int SHIFT_W  = $clog2(MAX_SHIFT + 1)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  din;
  logic [SHIFT_W-1:0]   shift;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] dout;
  logic                 sat;

  modport master (
    output in_valid, din, shift, mode, out_ready,
    input  in_ready, out_valid, dout, sat
  );

  modport slave (
    input  in_valid, din, shift, mode, out_ready,
    output in_ready, out_valid, dout, sat
  );
endinterface

// File: rtl/rounding_divider_pipe.sv
// rounding_divider_pipe
// Two-stage streaming divide by 2^shift with selectable rounding and
// saturation to OUT_WIDTH, plus a saturating count of saturated beats.
// Ports:
//   clk      : clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : rounding_divider_pipe_if.slave (in/out valid-ready streams)
//   sat_clr  : synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt  : number of saturated beats accepted downstream, sticks at 0xFFFF
// Optional feature macro: RDIV_HALF_EVEN_EN
//   defined   : mode 2 is round-half-even
//   undefined : mode 2 behaves as mode 1 (half-up)
module rounding_divider_pipe #(
  parameter int IN_WIDTH  = 35,
  parameter int OUT_WIDTH = 32,
  parameter int MAX_SHIFT = 7
) (
  input  logic                         clk,
  input  logic                         resetn,
  rounding_divider_pipe_if.slave       bus,
  input  logic                         sat_clr,
  output logic [15:0]                  sat_cnt
);
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [IN_WIDTH-1:0] ONE = {{(IN_WIDTH-1){1'b0}}, 1'b1};
  // Largest representable output, widened to the no-wrap sum width.
  localparam logic [IN_WIDTH:0] MAXOUT =
    {{(IN_WIDTH+1-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic [SHIFT_W-1:0]  s;
  logic [IN_WIDTH-1:0] q_c, r_c, mask_c, half_c;
  logic                inc_c, qovf_c;

  logic                s1_valid, s1_inc, s1_qovf;
  logic [IN_WIDTH-1:0] s1_q;
  logic                s2_valid;
  logic [OUT_WIDTH-1:0] dout_q, dout_c;
  logic                sat_q, sat_c;
  logic [IN_WIDTH:0]   sum_c;

  logic s2_ready, s1_adv, in_fire, out_fire;

  // The clamp only exists when the shift field can encode values past MAX_SHIFT.
  generate
    if (((2 ** SHIFT_W) - 1) > MAX_SHIFT) begin : g_clamp
      localparam logic [SHIFT_W-1:0] S_MAX = SHIFT_W'(MAX_SHIFT);
      assign s = (bus.shift > S_MAX) ? S_MAX : bus.shift;
    end else begin : g_noclamp
      assign s = bus.shift;
    end
  endgenerate

  always_comb begin
    q_c    = bus.din >> s;
    mask_c = ~({IN_WIDTH{1'b1}} << s);
    r_c    = bus.din & mask_c;
    // Only meaningful for s != 0; the s = 0 case never looks at it.
    half_c = ONE << (s - 1'b1);
    inc_c  = 1'b0;
    if (s != '0) begin
      case (bus.mode)
        2'd0: inc_c = 1'b0;
        2'd1: inc_c = (r_c >= half_c);
`ifdef RDIV_HALF_EVEN_EN
        2'd2: inc_c = (r_c > half_c) || ((r_c == half_c) && q_c[0]);
`else
        2'd2: inc_c = (r_c >= half_c);
`endif
        default: inc_c = (r_c != '0);
      endcase
    end
    qovf_c = ({1'b0, q_c} > MAXOUT);
  end

  always_comb begin
    sum_c  = {1'b0, s1_q} + {{IN_WIDTH{1'b0}}, s1_inc};
    sat_c  = s1_qovf || (sum_c > MAXOUT);
    dout_c = sat_c ? {OUT_WIDTH{1'b1}} : sum_c[OUT_WIDTH-1:0];
  end

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid && bus.out_ready;

  assign bus.out_valid = s2_valid;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_inc   <= 1'b0;
      s1_qovf  <= 1'b0;
      s2_valid <= 1'b0;
      dout_q   <= '0;
      sat_q    <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= q_c;
        s1_inc   <= inc_c;
        s1_qovf  <= qovf_c;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          dout_q <= dout_c;
          sat_q  <= sat_c;
        end
      end

      if (sat_clr) begin
        sat_cnt <= '0;
      end else if (out_fire && sat_q && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_rounding_divider_pipe.sv
module tb_rounding_divider_pipe;
  localparam int IW = 35;
  localparam int OW = 32;
  localparam int MS = 7;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;

  rounding_divider_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_SHIFT(MS)) bus ();

  rounding_divider_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_SHIFT(MS)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [32:0] sb[$];          // {sat, dout}
  logic [15:0] exp_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] hold_dout;
  logic        hold_sat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [32:0] model(input logic [34:0] d, input logic [2:0] sh,
                                        input logic [1:0] m);
    int s;
    logic [63:0] dd, q, r, h, res;
    logic inc;
    s   = (int'(sh) > MS) ? MS : int'(sh);
    dd  = 64'(d);
    q   = dd >> s;
    r   = dd - (q << s);
    h   = (s == 0) ? 64'd0 : (64'd1 << (s - 1));
    inc = 1'b0;
    if (s != 0) begin
      case (m)
        2'd1: inc = (r >= h);
`ifdef RDIV_HALF_EVEN_EN
        2'd2: inc = (r > h) || (r == h && q[0]);
`else
        2'd2: inc = (r >= h);
`endif
        2'd3: inc = (r != 0);
        default: inc = 1'b0;
      endcase
    end
    res = q + 64'(inc);
    if (res > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, res[31:0]};
  endfunction

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    logic        fire, e_sat;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      check("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
      fire  = bus.out_valid && bus.out_ready;
      e_sat = 1'b0;
      if (prev_stall && bus.out_valid) begin
        check("hold_dout", 64'(bus.dout), 64'(hold_dout));
        check("hold_sat", 64'(bus.sat), 64'(hold_sat));
      end
      if (fire) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("dout", 64'(bus.dout), 64'(e[31:0]));
          check("sat", 64'(bus.sat), 64'(e[32]));
          e_sat = e[32];
        end
      end
      if (sat_clr) exp_cnt = '0;
      else if (fire && e_sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      prev_stall = bus.out_valid && !bus.out_ready;
      hold_dout  = bus.dout;
      hold_sat   = bus.sat;
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [34:0] d, input logic [2:0] sh,
                     input logic [1:0] m, input logic ordy, output logic acc);
    bus.in_valid  = v;
    bus.din       = d;
    bus.shift     = sh;
    bus.mode      = m;
    bus.out_ready = ordy;
    @(negedge clk); #1;
    check("in_ready", 64'(bus.in_ready), 64'((sb.size() < 2) || ordy));
    acc = v && bus.in_ready;
    if (acc) sb.push_back(model(d, sh, m));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [34:0] d, input logic [2:0] sh, input logic [1:0] m);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) cyc(1'b1, d, sh, m, 1'b1, acc);
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 20 && sb.size() != 0; t++) cyc(1'b0, '0, '0, '0, 1'b1, acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    logic [34:0] rd;
    int sent;
    logic saw_low;

    bus.in_valid = 1'b0; bus.din = '0; bus.shift = '0; bus.mode = '0; bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_sat", 64'(bus.sat), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Rounding modes at shift 3
    for (int m = 0; m < 4; m++) send(35'd20, 3'd3, 2'(m));
    for (int m = 0; m < 4; m++) send(35'd28, 3'd3, 2'(m));
    for (int m = 0; m < 4; m++) send(35'd17, 3'd3, 2'(m));
    drain();

    // Saturation and shift edge cases
    send(35'h7_FFFF_FFFC, 3'd3, 2'd1);
    send(35'h7_FFFF_FFFC, 3'd3, 2'd0);
    send(35'h1_0000_0000, 3'd0, 2'd1);
    send(35'd5, 3'd0, 2'd2);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      rd = {3'($urandom_range(7, 0)), 32'($urandom)};
      cyc(1'($urandom_range(1, 0)), rd, 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
          1'($urandom_range(1, 0)), acc);
    end
    drain();

    // Backpressure: 6 beats, out_ready low in cycles 3..6
    sent = 0;
    saw_low = 1'b0;
    for (int c = 1; c <= 30 && (sent < 6 || sb.size() != 0); c++) begin
      cyc(sent < 6, 35'(100 + 7 * sent), 3'd2, 2'(sent), !(c >= 3 && c <= 6), acc);
      if (acc) sent++;
      if (c >= 3 && c <= 6 && !bus.in_ready) saw_low = 1'b1;
    end
    check("bp_sent", 64'(sent), 64'd6);
    check("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    drain();

    // Counter saturation
    for (int i = 0; i < 65540; i++) cyc(1'b1, 35'h1_0000_0000, 3'd0, 2'd0, 1'b1, acc);
    drain();
    check("cnt_stuck", 64'(sat_cnt), 64'hFFFF);

    // sat_clr coincident with a saturated transfer
    send(35'h1_0000_0000, 3'd0, 2'd0);
    @(posedge clk); #1;
    check("clr_out_valid", 64'(bus.out_valid), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("clr_wins", 64'(sat_cnt), 64'd0);
    drain();

    // Reset with both stages full
    send(35'h1_0000_0000, 3'd0, 2'd0);
    drain();
    check("cnt_one", 64'(sat_cnt), 64'd1);
    cyc(1'b1, 35'd40, 3'd1, 2'd0, 1'b0, acc);
    cyc(1'b1, 35'd41, 3'd1, 2'd0, 1'b0, acc);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_dout", 64'(bus.dout), 64'd0);
    sb.delete();
    exp_cnt = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale", 64'(bus.out_valid), 64'd0);
    end
    cyc(1'b1, 35'd9, 3'd1, 2'd1, 1'b1, acc);
    check("lat_accept", 64'(acc), 64'd1);
    check("lat_n1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_n2", 64'(bus.out_valid), 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
